sum_group_accumulator: RTL and testbench

- Downstream consumer of the A+B sum stream: takes the valid/ready sum stream and adds consecutive beats in groups of group_size.
- For each group it emits one widened total, plus the number of beats in that group, on a registered valid/ready output.
- A level flush input closes a partial group early, e.g. at end of a frame.
- Sits between the sum double buffer and the result sink.

---
 rtl/sum_group_accumulator_pkg.sv | 16 +
 rtl/sum_group_accumulator.sv | 80 ++++++++
 tb/tb_sum_group_accumulator.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_group_accumulator_pkg.sv
// Shared sizing helpers for the sum group accumulator and anything that
// consumes its output (sink, testbench), so bus widths stay identical.
//   acc_width_f : width of a group total for 'group_size' beats of 'width' bits
//   cnt_width_f : width of a beat count able to hold 0..group_size
package sum_group_accumulator_pkg;

    function automatic int unsigned acc_width_f(input int unsigned width,
                                                input int unsigned group_size);
        return width + $clog2(group_size);
    endfunction

    function automatic int unsigned cnt_width_f(input int unsigned group_size);
        return $clog2(group_size + 1);
    endfunction

endpackage

// File: rtl/sum_group_accumulator.sv
// Sum group accumulator: adds consecutive upstream sum beats in groups of
// group_size and emits one widened total plus the beat count per group on a
// registered valid/ready output. A level flush closes a partial group early.
//
// Ports:
//   clk        - clock, all state updates on posedge
//   rst        - synchronous active-low reset
//   up_valid   - upstream beat valid
//   up_ready   - block accepts the upstream beat this cycle
//   up_data    - upstream sum beat (unsigned, width bits)
//   flush      - level request to close the current partial group
//   down_valid - group result valid
//   down_ready - sink accepts the result
//   down_data  - unsigned sum of the group's beats (acc_width bits)
//   down_count - number of beats in the emitted group (1..group_size)
module sum_group_accumulator
    import sum_group_accumulator_pkg::*;
#(
    parameter int unsigned width      = 8,
    parameter int unsigned group_size = 4,
    localparam int unsigned acc_width = acc_width_f(width, group_size),
    localparam int unsigned cnt_width = cnt_width_f(group_size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [width-1:0]     up_data,
    input  logic                 flush,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [acc_width-1:0] down_data,
    output logic [cnt_width-1:0] down_count
);

    localparam logic [cnt_width-1:0] last_cnt = cnt_width'(group_size - 1);

    logic [acc_width-1:0] acc;
    logic [cnt_width-1:0] cnt;
    logic [acc_width-1:0] nxt_acc;
    logic [cnt_width-1:0] nxt_cnt;
    logic                 load_ok;
    logic                 up_fire;
    logic                 close;

    always_comb begin
        // Output register can take a new result if empty or draining now.
        load_ok  = !down_valid || down_ready;
        // Only the group-completing beat ever has to wait for the output.
        up_ready = (cnt != last_cnt) || load_ok;
        up_fire  = up_valid && up_ready;
        nxt_acc  = acc + (up_fire ? acc_width'(up_data) : '0);
        nxt_cnt  = cnt + cnt_width'(up_fire);
        close    = load_ok && ((up_fire && (cnt == last_cnt)) ||
                               (flush && (nxt_cnt != '0)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc        <= '0;
            cnt        <= '0;
            down_valid <= 1'b0;
            down_data  <= '0;
            down_count <= '0;
        end else if (close) begin
            // A close in the same cycle as a drain simply overwrites the
            // departing result, so down_valid stays high with no bubble.
            down_data  <= nxt_acc;
            down_count <= nxt_cnt;
            down_valid <= 1'b1;
            acc        <= '0;
            cnt        <= '0;
        end else begin
            acc        <= nxt_acc;
            cnt        <= nxt_cnt;
            down_valid <= down_valid && !down_ready;
        end
    end

endmodule

// File: tb/tb_sum_group_accumulator.sv
// Self-checking bench for sum_group_accumulator (width=8, group_size=4).
// Expected group results are queued as stimulus is driven and compared when
// the DUT hands a result downstream.
module tb_sum_group_accumulator;
    import sum_group_accumulator_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned G  = 4;
    localparam int unsigned AW = acc_width_f(W, G);
    localparam int unsigned CW = cnt_width_f(G);

    typedef struct packed {
        logic [AW-1:0] data;
        logic [CW-1:0] count;
    } res_t;

    logic          clk;
    logic          rst;
    logic          up_valid;
    logic          up_ready;
    logic [W-1:0]  up_data;
    logic          flush;
    logic          down_valid;
    logic          down_ready;
    logic [AW-1:0] down_data;
    logic [CW-1:0] down_count;

    int   checks;
    int   errors;
    res_t exp_q[$];

    sum_group_accumulator #(
        .width      (W),
        .group_size (G)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .up_data    (up_data),
        .flush      (flush),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .down_data  (down_data),
        .down_count (down_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int unsigned d, input int unsigned c);
        res_t r;
        r.data  = AW'(d);
        r.count = CW'(c);
        exp_q.push_back(r);
    endtask

    // Inputs change 1 time unit after posedge; outputs sampled at negedge.
    always @(negedge clk) begin
        if (rst && down_valid && down_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_result", 32'(down_data), 32'hFFFF_FFFF);
            end else begin
                res_t r;
                r = exp_q.pop_front();
                check_eq("down_data", 32'(down_data), 32'(r.data));
                check_eq("down_count", 32'(down_count), 32'(r.count));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded); reports whether
    // the beat was not accepted on its first cycle.
    task automatic send(input int unsigned d, input logic fl, output logic stalled);
        int unsigned n;
        n        = 0;
        up_valid = 1'b1;
        up_data  = W'(d);
        flush    = fl;
        @(negedge clk);
        stalled = !up_ready;
        while (!up_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!up_ready) check_eq("send_timeout", 32'(up_ready), 32'd1);
        tick();
        up_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send_group(input int unsigned d0, input int unsigned d1,
                              input int unsigned d2, input int unsigned d3);
        logic s;
        send(d0, 1'b0, s);
        send(d1, 1'b0, s);
        send(d2, 1'b0, s);
        send(d3, 1'b0, s);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic s;
        checks     = 0;
        errors     = 0;
        rst        = 1'b0;
        up_valid   = 1'b0;
        up_data    = '0;
        flush      = 1'b0;
        down_ready = 1'b1;
        idle(3);
        check_eq("rst_down_valid", 32'(down_valid), 32'd0);
        check_eq("rst_down_data", 32'(down_data), 32'd0);
        check_eq("rst_down_count", 32'(down_count), 32'd0);
        check_eq("rst_up_ready", 32'(up_ready), 32'd1);
        rst = 1'b1;
        idle(1);

        // Full group, output visible the cycle after the 4th accept, then gone.
        push_exp(100, 4);
        send_group(10, 20, 30, 40);
        check_eq("full_valid_after", 32'(down_valid), 32'd1);
        tick();
        check_eq("full_valid_drop", 32'(down_valid), 32'd0);

        // Widest total.
        push_exp(1020, 4);
        send_group(255, 255, 255, 255);
        idle(2);

        // Backpressure: stream 1..8 with the sink stalled.
        down_ready = 1'b0;
        push_exp(10, 4);
        push_exp(26, 4);
        for (int unsigned b = 1; b <= 7; b++) begin
            send(b, 1'b0, s);
            check_eq("bp_no_stall", 32'(s), 32'd0);
        end
        up_valid = 1'b1;
        up_data  = 8'd8;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_up_ready_low", 32'(up_ready), 32'd0);
            check_eq("bp_held_data", 32'(down_data), 32'd10);
            check_eq("bp_held_valid", 32'(down_valid), 32'd1);
        end
        tick();
        down_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_release_ready", 32'(up_ready), 32'd1);
        tick();
        up_valid = 1'b0;
        check_eq("bp_second_valid", 32'(down_valid), 32'd1);
        idle(2);
        check_eq("bp_drained", 32'(down_valid), 32'd0);

        // Partial group closed by flush on the third beat.
        push_exp(18, 3);
        send(5, 1'b0, s);
        send(6, 1'b0, s);
        send(7, 1'b1, s);
        idle(2);

        // Empty flush produces nothing.
        flush = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check_eq("empty_flush", 32'(down_valid), 32'd0);
        end
        flush = 1'b0;

        // Flush and full group coincide: single close of group_size.
        push_exp(10, 4);
        send(1, 1'b0, s);
        send(2, 1'b0, s);
        send(3, 1'b0, s);
        send(4, 1'b1, s);
        idle(2);
        check_eq("flush_full_single", 32'(down_valid), 32'd0);

        // Flush while the output is held: waits for release.
        down_ready = 1'b0;
        push_exp(12, 4);
        push_exp(5, 1);
        send_group(3, 3, 3, 3);
        send(5, 1'b0, s);
        flush = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check_eq("held_flush_data", 32'(down_data), 32'd12);
            check_eq("held_flush_count", 32'(down_count), 32'd4);
        end
        down_ready = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("held_flush_valid", 32'(down_valid), 32'd1);
        check_eq("held_flush_new", 32'(down_data), 32'd5);
        idle(2);

        // Reset mid-group discards partial beats.
        send(9, 1'b0, s);
        send(9, 1'b0, s);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_eq("mid_rst_valid", 32'(down_valid), 32'd0);
        check_eq("mid_rst_data", 32'(down_data), 32'd0);
        check_eq("mid_rst_count", 32'(down_count), 32'd0);
        push_exp(4, 4);
        send_group(1, 1, 1, 1);
        idle(2);

        // Simultaneous drain and load.
        down_ready = 1'b0;
        push_exp(100, 4);
        push_exp(8, 4);
        send_group(25, 25, 25, 25);
        send(2, 1'b0, s);
        send(2, 1'b0, s);
        send(2, 1'b0, s);
        down_ready = 1'b1;
        send(2, 1'b0, s);
        check_eq("swap_valid", 32'(down_valid), 32'd1);
        check_eq("swap_data", 32'(down_data), 32'd8);
        idle(3);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

endmodule
